// File: rtl/reg_port_arbiter_pkg.sv
// Shared definitions for the register-port arbiter.
//   - address / data widths of the byte-serial register file
//   - FSM state encoding (3-bit)
//   - helper that picks the state following the address phase
package reg_port_arbiter_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ADDR = 3'd1,
    S_DATA = 3'd2,
    S_REL  = 3'd3,
    S_WAIT = 3'd4,
    S_DONE = 3'd5
  } arb_state_e;

  // A write continues with its data phase; a read waits for the register file.
  function automatic arb_state_e after_addr(input logic we);
    return we ? S_DATA : S_WAIT;
  endfunction

endpackage

// File: rtl/reg_port_arbiter_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    in   NREQ    request vector
//   ptr    in   IDX_W   index of the last winner (search starts just after it)
//   onehot out  NREQ    one-hot winner, 0 when nothing is requested
//   idx    out  IDX_W   winner index, 0 when nothing is requested
//   any    out  1       at least one request present
module reg_port_arbiter_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  logic [IDX_W-1:0] cand;

  // Scan from the farthest candidate back to the nearest one, so the last
  // hit written is the first requester after the pointer.
  always_comb begin
    idx  = {IDX_W{1'b0}};
    any  = 1'b0;
    cand = {IDX_W{1'b0}};
    for (int i = NREQ; i >= 1; i--) begin
      cand = IDX_W'((int'(ptr) + i) % NREQ);
      any  = any | req[cand];
      idx  = req[cand] ? cand : idx;
    end
    onehot = any ? ({{(NREQ-1){1'b0}}, 1'b1} << idx) : {NREQ{1'b0}};
  end

endmodule

// File: rtl/reg_port_arbiter.sv
// Round-robin arbiter sharing one byte-serial register file among NREQ
// requesters. Runs one transaction at a time:
//   write: address phase, data phase, strobe release, completion
//   read : address phase, wait for reg_valid (bounded by TIMEOUT), completion
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   req/req_we             per-requester request level and direction
//   req_addr/req_wdata     packed per-requester address / write data (8 bits each)
//   gnt                    one-hot owner, high for the whole transaction
//   done, err              one-cycle completion pulse (err: read timed out)
//   rdata                  read result, valid in the done cycle, held afterwards
//   reg_data_in/reg_write/reg_read    strobes towards the register file
//   reg_data_out/reg_valid            response from the register file
module reg_port_arbiter
  import reg_port_arbiter_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          req_we,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  input  logic [NREQ*DATA_W-1:0]   req_wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [DATA_W-1:0]        rdata,
  output logic                     err,
  output logic [DATA_W-1:0]        reg_data_in,
  output logic                     reg_write,
  output logic                     reg_read,
  input  logic [DATA_W-1:0]        reg_data_out,
  input  logic                     reg_valid
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state;
  logic [IDX_W-1:0]  ptr;
  logic              we_lat;
  logic [DATA_W-1:0] wdata_lat;
  logic [CNT_W-1:0]  wait_cnt;

  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_any;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  reg_port_arbiter_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req    (req),
    .ptr    (ptr),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .any    (pick_any)
  );

  // Route the current winner's direction, address and data to the latches.
  always_comb begin
    sel_we    = req_we[pick_idx];
    sel_addr  = {ADDR_W{1'b0}};
    sel_wdata = {DATA_W{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_addr  = (pick_idx == IDX_W'(i)) ? req_addr[i*ADDR_W +: ADDR_W]   : sel_addr;
      sel_wdata = (pick_idx == IDX_W'(i)) ? req_wdata[i*DATA_W +: DATA_W] : sel_wdata;
    end
  end

  // Transaction FSM. Outputs are registered: each transition loads the values
  // that belong to the state being entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      ptr         <= IDX_W'(NREQ - 1);
      we_lat      <= 1'b0;
      wdata_lat   <= {DATA_W{1'b0}};
      wait_cnt    <= {CNT_W{1'b0}};
      gnt         <= {NREQ{1'b0}};
      done        <= {NREQ{1'b0}};
      err         <= 1'b0;
      rdata       <= {DATA_W{1'b0}};
      reg_data_in <= {DATA_W{1'b0}};
      reg_write   <= 1'b0;
      reg_read    <= 1'b0;
    end else begin
      done <= {NREQ{1'b0}};
      err  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_any) begin
            ptr         <= pick_idx;
            we_lat      <= sel_we;
            wdata_lat   <= sel_wdata;
            gnt         <= pick_onehot;
            reg_data_in <= sel_addr;
            reg_write   <= sel_we;
            reg_read    <= ~sel_we;
            state       <= S_ADDR;
          end else begin
            state <= S_IDLE;
          end
        end
        S_ADDR: begin
          state <= after_addr(we_lat);
          if (we_lat) begin
            reg_data_in <= wdata_lat;
            reg_write   <= 1'b1;
            reg_read    <= 1'b0;
          end else begin
            // Address stays on reg_data_in while waiting.
            reg_write <= 1'b0;
            reg_read  <= 1'b0;
            wait_cnt  <= CNT_W'(1);
          end
        end
        S_DATA: begin
          reg_write <= 1'b0;
          state     <= S_REL;
        end
        S_REL: begin
          done  <= gnt;
          state <= S_DONE;
        end
        S_WAIT: begin
          // A valid in the last permitted cycle still counts as success.
          if (reg_valid) begin
            rdata <= reg_data_out;
            done  <= gnt;
            state <= S_DONE;
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            rdata <= {DATA_W{1'b0}};
            err   <= 1'b1;
            done  <= gnt;
            state <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          gnt   <= {NREQ{1'b0}};
          state <= S_IDLE;
        end
        default: begin
          gnt       <= {NREQ{1'b0}};
          reg_write <= 1'b0;
          reg_read  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_port_arbiter.sv
// Self-checking bench for reg_port_arbiter: randomized requesters, a
// transaction-level reference model predicting winner, completion cycle and
// read result, and a scoreboard monitor comparing the DUT cycle by cycle.
module tb_reg_port_arbiter;

  localparam int NREQ    = 4;
  localparam int TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req, req_we;
  logic [NREQ*8-1:0] req_addr, req_wdata;
  logic [NREQ-1:0]   gnt, done;
  logic [7:0]        rdata, reg_data_in, reg_data_out;
  logic              err, reg_write, reg_read, reg_valid;

  reg_port_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata), .err(err),
    .reg_data_in(reg_data_in), .reg_write(reg_write), .reg_read(reg_read),
    .reg_data_out(reg_data_out), .reg_valid(reg_valid)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    int start_c; int done_c; int owner; int lat;
    bit we; bit err;
    logic [7:0] addr; logic [7:0] wdata; logic [7:0] rdata;
  } exp_t;

  typedef struct {
    bit v; bit we; logic [7:0] addr; logic [7:0] wdata; int lat;
  } slot_t;

  exp_t  sb[$];
  slot_t slots[NREQ];
  logic [7:0] ref_mem[256];
  logic [7:0] env_mem[256];
  logic [7:0] env_rd_addr, env_waddr;
  bit         env_wphase;
  bit         mon_en = 1'b0;
  int         zero_chk_cyc = -1;

  // model state (stimulus process only)
  bit         busy, hold, random_fill, drop_at_addr;
  exp_t       cur;
  int         mptr;
  logic [7:0] model_rdata;

  assign reg_data_out = env_mem[env_rd_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Monitor / scoreboard plus register-file environment.
  always @(negedge clk) begin
    exp_t e;
    bit have, active;
    logic [NREQ-1:0] eg;
    logic [7:0] mon_rdata_exp;
    if (!mon_en) begin
      for (int i = 0; i < 256; i++) env_mem[i] = 8'h00;
      env_rd_addr = 8'h00; env_waddr = 8'h00; env_wphase = 1'b0;
    end else begin
      if (cyc == zero_chk_cyc) begin
        sb.delete();
        env_wphase = 1'b0;
        chk("reset_data_in", reg_data_in, 0);
        chk("reset_rdata", rdata, 0);
      end
      have = (sb.size() > 0);
      e = have ? sb[0] : '{default: 0};
      active = have && (cyc > e.start_c) && (cyc <= e.done_c);
      eg = '0;
      if (active) eg[e.owner] = 1'b1;
      chk("gnt", gnt, eg);
      chk("rw_exclusive", reg_write & reg_read, 0);
      chk("reg_write", reg_write, active && e.we && (cyc == e.start_c+1 || cyc == e.start_c+2));
      chk("reg_read", reg_read, active && !e.we && cyc == e.start_c+1);
      if (active) chk("reg_data_in", reg_data_in, (e.we && cyc >= e.start_c+2) ? e.wdata : e.addr);
      if (have && cyc == e.done_c) begin
        chk("done", done, eg);
        chk("err", err, e.err);
        chk("rdata", rdata, e.rdata);
        void'(sb.pop_front());
      end else begin
        chk("no_done", done, 0);
        chk("no_err", err, 0);
      end
      // register file behaviour: two write strobes = address then data
      if (reg_write) begin
        if (!env_wphase) begin env_waddr = reg_data_in; env_wphase = 1'b1; end
        else begin env_mem[env_waddr] = reg_data_in; env_wphase = 1'b0; end
      end
      if (reg_read) env_rd_addr = reg_data_in;
    end
  end

  function automatic slot_t rand_slot();
    slot_t s; int r;
    s.v = 1'b1; s.we = 1'($urandom); s.addr = 8'($urandom_range(0, 7));
    s.wdata = 8'($urandom);
    r = $urandom_range(0, 9);
    s.lat = (r == 0) ? 0 : (r == 1) ? 1 : (r == 2) ? TIMEOUT : $urandom_range(1, TIMEOUT);
    return s;
  endfunction

  task automatic put(input int i, input bit we, input logic [7:0] a, input logic [7:0] d, input int lat);
    slots[i] = '{1'b1, we, a, d, lat};
  endtask

  // One clock of stimulus plus the transaction-level model for that cycle.
  task automatic step();
    int c, w;
    bit found, in_wait;
    logic [NREQ-1:0] vis;
    @(posedge clk); #1;
    c = cyc;
    if (busy && c > cur.done_c) busy = 1'b0;
    if (busy && c > cur.start_c && (drop_at_addr || $urandom_range(0, 5) == 0)) hold = 1'b0;
    if (random_fill)
      for (int i = 0; i < NREQ; i++)
        if (!slots[i].v && !(busy && i == cur.owner) && $urandom_range(0, 3) == 0) slots[i] = rand_slot();
    vis = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*8 +: 8]  = 8'($urandom);
      req_wdata[i*8 +: 8] = 8'($urandom);
      req_we[i]           = 1'($urandom);
      if (slots[i].v) begin
        vis[i] = 1'b1;
        req_we[i] = slots[i].we;
        req_addr[i*8 +: 8] = slots[i].addr;
        req_wdata[i*8 +: 8] = slots[i].wdata;
      end
    end
    if (busy && hold) vis[cur.owner] = 1'b1;
    req = vis;
    in_wait = busy && !cur.we && c >= cur.start_c+2 && c <= cur.done_c;
    reg_valid = in_wait ? (cur.lat != 0 && c == cur.start_c + 1 + cur.lat)
                        : ($urandom_range(0, 3) == 0);
    if (!busy && !rst && vis != '0) begin
      found = 1'b0; w = 0;
      for (int k = 1; k <= NREQ; k++)
        if (!found && vis[(mptr + k) % NREQ]) begin found = 1'b1; w = (mptr + k) % NREQ; end
      mptr = w;
      cur.owner = w; cur.start_c = c; cur.we = slots[w].we; cur.addr = slots[w].addr;
      cur.wdata = slots[w].wdata; cur.lat = slots[w].lat; cur.err = 1'b0;
      if (cur.we) begin
        cur.done_c = c + 4;
        ref_mem[cur.addr] = cur.wdata;
      end else if (cur.lat != 0) begin
        cur.done_c = c + 2 + cur.lat;
        model_rdata = ref_mem[cur.addr];
      end else begin
        cur.done_c = c + 2 + TIMEOUT;
        model_rdata = 8'h00;
        cur.err = 1'b1;
      end
      cur.rdata = model_rdata;
      sb.push_back(cur);
      slots[w].v = 1'b0;
      busy = 1'b1; hold = 1'b1;
    end
  endtask

  task automatic drain();
    bit pend;
    for (int n = 0; n < 400; n++) begin
      pend = busy;
      for (int i = 0; i < NREQ; i++) pend = pend | slots[i].v;
      if (pend) step();
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0; reg_valid = 1'b0;
    busy = 1'b0; hold = 1'b0; random_fill = 1'b0; drop_at_addr = 1'b0;
    mptr = NREQ - 1; model_rdata = 8'h00; cur = '{default: 0};
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
    for (int i = 0; i < NREQ; i++) slots[i] = '{default: 0};
    repeat (2) @(posedge clk);
    #1;
    zero_chk_cyc = cyc; mon_en = 1'b1; rst = 1'b0;

    // single write, read back, register file content
    put(0, 1'b1, 8'h02, 8'hA5, 0); drain();
    put(1, 1'b0, 8'h02, 8'h00, 3); drain();
    chk("regfile_addr2", env_mem[2], 8'hA5);

    // timeout, then normal service including valid on the last allowed cycle
    put(0, 1'b0, 8'h03, 8'h00, 0); drain();
    put(3, 1'b0, 8'h02, 8'h00, TIMEOUT); drain();
    put(1, 1'b0, 8'h02, 8'h00, 1); drain();

    // requester drops req during the address phase
    drop_at_addr = 1'b1;
    put(3, 1'b1, 8'h06, 8'h3C, 0); drain();
    put(3, 1'b0, 8'h06, 8'h00, 2); drain();
    drop_at_addr = 1'b0;

    // contention: everyone writes, then everyone reads
    for (int i = 0; i < NREQ; i++) put(i, 1'b1, 8'(4 + i), 8'(8'h50 + i), 0);
    drain();
    for (int i = 0; i < NREQ; i++) put(i, 1'b0, 8'(4 + i), 8'h00, i + 1);
    drain();

    // reset during the data phase of a write
    put(1, 1'b1, 8'hFF, 8'h5A, 0);
    for (int n = 0; n < 50 && !(busy && cyc == cur.start_c + 1); n++) step();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; reg_valid = 1'b0; zero_chk_cyc = cyc + 1;
    @(posedge clk); #1;
    busy = 1'b0; hold = 1'b0; mptr = NREQ - 1; model_rdata = 8'h00;
    for (int i = 0; i < NREQ; i++) slots[i].v = 1'b0;
    rst = 1'b0;
    put(2, 1'b0, 8'h02, 8'h00, 2); drain();

    // randomized traffic
    random_fill = 1'b1;
    repeat (3000) step();
    random_fill = 1'b0;
    drain();
    repeat (3) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
